// File: rtl/instruction_fetch.sv
// Wishbone classic instruction prefetcher: sequential word fetch into a small FIFO,
// with branch redirect (flush plus stale-response drain) and fault-tagged bus errors.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        instr_fault_o,
  output logic        cyc_o,
  output logic        stb_o,
  output logic [31:0] adr_o,
  output logic [3:0]  sel_o,
  output logic        we_o,
  output logic [31:0] dat_o,
  input  logic [31:0] dat_i,
  input  logic        ack_i,
  input  logic        err_i,
  input  logic        rty_i
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_DRAIN,
    S_HALT
  } state_t;

  state_t          r_state;
  logic            r_cyc;
  logic [31:0]     r_adr;
  logic [31:0]     r_pc;
  logic [CW-1:0]   r_count;
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [31:0]     r_mem_data  [DEPTH];
  logic [31:0]     r_mem_pc    [DEPTH];
  logic            r_mem_fault [DEPTH];

  state_t          w_state_n;
  logic            w_cyc_n;
  logic [31:0]     w_adr_n;
  logic [31:0]     w_pc_n;
  logic            w_push;
  logic            w_push_fault;
  logic            w_flush;
  logic            w_pop;
  logic            w_err;
  logic            w_ack;
  logic            w_rty;
  logic            w_term;
  logic [CW-1:0]   w_cnt_ack;
  logic [31:0]     w_redir_pc;
  logic            w_unused;

  assign w_unused   = ^redirect_pc_i[1:0];
  assign w_redir_pc = {redirect_pc_i[31:2], 2'b00};

  // Terminations only count while a cycle is open; err beats ack beats rty.
  assign w_err  = r_cyc & err_i;
  assign w_ack  = r_cyc & ack_i & ~err_i;
  assign w_rty  = r_cyc & rty_i & ~err_i & ~ack_i;
  assign w_term = r_cyc & (ack_i | err_i | rty_i);

  assign w_pop     = (r_count != '0) & instr_ready_i & ~redirect_i;
  assign w_cnt_ack = r_count + CW'(1) - CW'(w_pop);

  always_comb begin
    w_state_n    = r_state;
    w_cyc_n      = r_cyc;
    w_adr_n      = r_adr;
    w_pc_n       = r_pc;
    w_push       = 1'b0;
    w_push_fault = 1'b0;
    w_flush      = 1'b0;

    unique case (r_state)
      S_FETCH: begin
        if (r_cyc) begin
          if (w_err) begin
            w_push       = 1'b1;
            w_push_fault = 1'b1;
            w_cyc_n      = 1'b0;
            w_state_n    = S_HALT;
          end else if (w_ack) begin
            w_push = 1'b1;
            w_pc_n = r_pc + 32'd4;
            if (w_cnt_ack < DEPTH_C) begin
              w_adr_n = r_pc + 32'd4;
            end else begin
              w_cyc_n   = 1'b0;
              w_state_n = S_WAIT;
            end
          end else if (w_rty) begin
            w_cyc_n = 1'b0;
          end
        end else if (r_count < DEPTH_C) begin
          w_cyc_n = 1'b1;
          w_adr_n = r_pc;
        end
      end
      S_WAIT: begin
        if (r_count < DEPTH_C) begin
          w_cyc_n   = 1'b1;
          w_adr_n   = r_pc;
          w_state_n = S_FETCH;
        end
      end
      S_DRAIN: begin
        if (w_term) begin
          w_cyc_n   = 1'b0;
          w_state_n = S_FETCH;
        end
      end
      default: ;
    endcase

    // Redirect overrides the per-state result; an open, unterminated cycle must
    // run to completion in DRAIN so its response is not mistaken for new data.
    if (redirect_i) begin
      w_flush      = 1'b1;
      w_push       = 1'b0;
      w_push_fault = 1'b0;
      w_pc_n       = w_redir_pc;
      if (r_state != S_DRAIN) begin
        if (r_cyc && !w_term) begin
          w_state_n = S_DRAIN;
          w_cyc_n   = 1'b1;
          w_adr_n   = r_adr;
        end else begin
          w_state_n = S_FETCH;
          w_cyc_n   = 1'b1;
          w_adr_n   = w_redir_pc;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= S_FETCH;
      r_cyc    <= 1'b0;
      r_adr    <= RESET_PC;
      r_pc     <= RESET_PC;
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_state <= w_state_n;
      r_cyc   <= w_cyc_n;
      r_adr   <= w_adr_n;
      r_pc    <= w_pc_n;
      if (w_flush) begin
        r_count  <= '0;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr]  <= w_push_fault ? '0 : dat_i;
      r_mem_pc[r_wr_ptr]    <= r_adr;
      r_mem_fault[r_wr_ptr] <= w_push_fault;
    end
  end

  assign instr_valid_o = (r_count != '0);
  assign instr_o       = instr_valid_o ? r_mem_data[r_rd_ptr]  : '0;
  assign instr_pc_o    = instr_valid_o ? r_mem_pc[r_rd_ptr]    : '0;
  assign instr_fault_o = instr_valid_o ? r_mem_fault[r_rd_ptr] : 1'b0;

  assign cyc_o = r_cyc;
  assign stb_o = r_cyc;
  assign adr_o = r_adr;
  assign sel_o = 4'b1111;
  assign we_o  = 1'b0;
  assign dat_o = '0;

endmodule
